cplx_delay_line: RTL and testbench

- Parametrised successor to the single-stage 32-bit sample register used in the complex-multiplier datapath.
- Delays packed complex samples {re, im} by a runtime-selectable number of clock-enabled stages, from 1 to DEPTH.
- Tracks per-stage valid bits, supports stall and flush, and reports when the pipe is primed.
- Sits between FFT butterfly and twiddle-multiplier stages to align data against twiddle and control paths.

---
 rtl/cplx_delay_line.sv | 107 ++++++++++
 tb/tb_cplx_delay_line.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_delay_line.sv
// cplx_delay_line
//   Clock-enabled delay line for packed complex samples {re, im}. The
//   delay is selectable at run time from 1 to DEPTH stages. Each stage
//   carries a valid bit. The line supports stall (EN=0) and flush, and
//   it reports when enough enabled cycles have elapsed to fill the
//   selected tap.
//
// Ports
//   CLK       in   clock, rising edge
//   RSTN      in   synchronous active-low reset (priority over FLUSH/EN)
//   EN        in   advance enable; 0 holds all state
//   FLUSH     in   clears valid bits and prime counter, keeps data
//   DLY_SEL   in   requested delay, clamped to 1..DEPTH
//   IN_VALID  in   qualifier for IN_DATA
//   IN_DATA   in   packed complex sample
//   OUT_VALID out  valid bit of the selected tap
//   OUT_DATA  out  data of the selected tap (combinational mux)
//   PRIMED    out  prime counter >= effective delay
//   CFG_ERR   out  sticky: DLY_SEL was 0 or above DEPTH
module cplx_delay_line #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int SEL_W  = 7
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              EN,
    input  logic              FLUSH,
    input  logic [SEL_W-1:0]  DLY_SEL,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              PRIMED,
    output logic              CFG_ERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [CNT_W-1:0]  prime_cnt;
    logic              cfg_err_q;

    logic [SEL_W-1:0]  dly;
    logic              sel_bad;
    logic [IDX_W-1:0]  tap;

    // Clamp the requested delay into 1..DEPTH and flag out-of-range requests.
    always_comb begin
        dly     = DLY_SEL;
        sel_bad = 1'b0;
        if (DLY_SEL == '0) begin
            dly     = SEL_W'(1);
            sel_bad = 1'b1;
        end else if (DLY_SEL > DEPTH_SEL) begin
            dly     = DEPTH_SEL;
            sel_bad = 1'b1;
        end
    end

    always_comb begin
        tap = IDX_W'(dly - SEL_W'(1));
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q   <= '0;
            prime_cnt <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (sel_bad) begin
                cfg_err_q <= 1'b1;
            end
            if (FLUSH) begin
                // Data registers keep their contents; only qualification is dropped.
                valid_q   <= '0;
                prime_cnt <= '0;
            end else if (EN) begin
                data_q[0]  <= IN_DATA;
                valid_q[0] <= IN_VALID;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
                if (prime_cnt != CNT_MAX) begin
                    prime_cnt <= prime_cnt + CNT_W'(1);
                end
            end
        end
    end

    // The tap follows DLY_SEL immediately; there is no re-alignment of the data.
    always_comb begin
        OUT_DATA  = data_q[tap];
        OUT_VALID = valid_q[tap];
        PRIMED    = (SEL_W'(prime_cnt) >= dly);
        CFG_ERR   = cfg_err_q;
    end

endmodule

// File: tb/tb_cplx_delay_line.sv
module tb_cplx_delay_line;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        EN;
    logic        FLUSH;
    logic [6:0]  DLY_SEL;
    logic        IN_VALID;
    logic [31:0] IN_DATA;
    logic        OUT_VALID;
    logic [31:0] OUT_DATA;
    logic        PRIMED;
    logic        CFG_ERR;

    int errors = 0;
    int checks = 0;

    cplx_delay_line #(
        .DATA_W(32),
        .DEPTH (8),
        .SEL_W (7)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .EN       (EN),
        .FLUSH    (FLUSH),
        .DLY_SEL  (DLY_SEL),
        .IN_VALID (IN_VALID),
        .IN_DATA  (IN_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_DATA (OUT_DATA),
        .PRIMED   (PRIMED),
        .CFG_ERR  (CFG_ERR)
    );

    always #5 CLK = ~CLK;

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN     = 1'b0;
        EN       = 1'b1;
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        step();
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        RSTN     = 1'b0;
        EN       = 1'b1;
        FLUSH    = 1'b0;
        DLY_SEL  = 7'd5;
        IN_VALID = 1'b1;
        IN_DATA  = 32'hFFFF_FFFF;
        step();
        step();
        checks++; if (OUT_DATA !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", OUT_DATA); end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", OUT_VALID); end
        checks++; if (PRIMED !== 1'b0) begin errors++; $display("FAIL reset_primed got %b exp 0", PRIMED); end
        checks++; if (CFG_ERR !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", CFG_ERR); end
    endtask

    // d=5: after enabled edge e, the output is sample e-5 (the capture edge counts).
    task automatic test_basic_latency();
        logic [31:0] exp_d;
        logic        exp_v;
        DLY_SEL = 7'd5;
        do_reset();
        IN_VALID = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            IN_DATA = 32'h0001_0000 + 32'(e - 1);
            step();
            exp_v = (e >= 5);
            exp_d = exp_v ? 32'h0001_0000 + 32'(e - 5) : 32'h0;
            checks++; if (OUT_DATA !== exp_d) begin errors++; $display("FAIL lat_data e=%0d got %h exp %h", e, OUT_DATA, exp_d); end
            checks++; if (OUT_VALID !== exp_v) begin errors++; $display("FAIL lat_valid e=%0d got %b exp %b", e, OUT_VALID, exp_v); end
            checks++; if (PRIMED !== exp_v) begin errors++; $display("FAIL lat_primed e=%0d got %b exp %b", e, PRIMED, exp_v); end
        end
    endtask

    // d=3: 5 enabled edges, 4 stalled edges, 5 enabled edges.
    task automatic test_stall();
        int          c;
        int          n;
        logic [31:0] exp_d;
        DLY_SEL = 7'd3;
        do_reset();
        c = 0;
        n = 0;
        for (int w = 1; w <= 14; w++) begin
            if (w >= 6 && w <= 9) begin
                EN       = 1'b0;
                IN_VALID = 1'b1;
                IN_DATA  = 32'hDEAD_BEEF;
            end else begin
                EN       = 1'b1;
                IN_VALID = 1'b1;
                IN_DATA  = 32'h0002_0000 + 32'(n);
                n++;
                c++;
            end
            step();
            if (c >= 3) begin
                exp_d = 32'h0002_0000 + 32'(c - 3);
                checks++; if (OUT_DATA !== exp_d) begin errors++; $display("FAIL stall_data w=%0d got %h exp %h", w, OUT_DATA, exp_d); end
                checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL stall_valid w=%0d got %b exp 1", w, OUT_VALID); end
                checks++; if (PRIMED !== 1'b1) begin errors++; $display("FAIL stall_primed w=%0d got %b exp 1", w, PRIMED); end
            end
        end
        // Sample 4 was captured at wall edge 5 and must appear at wall edge 11 (3 + 4 edges total).
        EN = 1'b1;
    endtask

    task automatic test_flush();
        logic [31:0] exp_d;
        logic        exp_v;
        DLY_SEL = 7'd4;
        do_reset();
        IN_VALID = 1'b1;
        for (int n = 0; n < 6; n++) begin
            IN_DATA = 32'h0003_0000 + 32'(n);
            step();
        end
        checks++; if (OUT_DATA !== 32'h0003_0002) begin errors++; $display("FAIL flush_prefill got %h exp 00030002", OUT_DATA); end
        FLUSH   = 1'b1;
        IN_DATA = 32'h3BAD_0000;
        step();
        FLUSH = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_valid0 got %b exp 0", OUT_VALID); end
        checks++; if (PRIMED !== 1'b0) begin errors++; $display("FAIL flush_primed0 got %b exp 0", PRIMED); end
        for (int k = 1; k <= 6; k++) begin
            IN_DATA = 32'h0003_0010 + 32'(k - 1);
            step();
            exp_v = (k >= 4);
            checks++; if (OUT_VALID !== exp_v) begin errors++; $display("FAIL flush_valid k=%0d got %b exp %b", k, OUT_VALID, exp_v); end
            checks++; if (PRIMED !== exp_v) begin errors++; $display("FAIL flush_primed k=%0d got %b exp %b", k, PRIMED, exp_v); end
            if (exp_v) begin
                exp_d = 32'h0003_0010 + 32'(k - 4);
                checks++; if (OUT_DATA !== exp_d) begin errors++; $display("FAIL flush_data k=%0d got %h exp %h", k, OUT_DATA, exp_d); end
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] exp_d;
        logic        exp_v;
        DLY_SEL = 7'd0;
        do_reset();
        IN_VALID = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            IN_DATA = 32'h0004_0000 + 32'(e - 1);
            step();
            exp_d = 32'h0004_0000 + 32'(e - 1);
            checks++; if (OUT_DATA !== exp_d) begin errors++; $display("FAIL range0_data e=%0d got %h exp %h", e, OUT_DATA, exp_d); end
            checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL range0_valid e=%0d got %b exp 1", e, OUT_VALID); end
            checks++; if (CFG_ERR !== 1'b1) begin errors++; $display("FAIL range0_cfg_err e=%0d got %b exp 1", e, CFG_ERR); end
        end
        // d clamps to 8; the tap moves to s[7], still holding reset zeros.
        DLY_SEL = 7'd12;
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL range12_valid_now got %b exp 0", OUT_VALID); end
        checks++; if (PRIMED !== 1'b0) begin errors++; $display("FAIL range12_primed_now got %b exp 0", PRIMED); end
        for (int e = 4; e <= 11; e++) begin
            IN_DATA = 32'h0004_0000 + 32'(e - 1);
            step();
            exp_v = (e >= 8);
            checks++; if (OUT_VALID !== exp_v) begin errors++; $display("FAIL range12_valid e=%0d got %b exp %b", e, OUT_VALID, exp_v); end
            checks++; if (PRIMED !== exp_v) begin errors++; $display("FAIL range12_primed e=%0d got %b exp %b", e, PRIMED, exp_v); end
            if (exp_v) begin
                exp_d = 32'h0004_0000 + 32'(e - 8);
                checks++; if (OUT_DATA !== exp_d) begin errors++; $display("FAIL range12_data e=%0d got %h exp %h", e, OUT_DATA, exp_d); end
            end
        end
        DLY_SEL = 7'd2;
        FLUSH   = 1'b1;
        step();
        FLUSH = 1'b0;
        checks++; if (CFG_ERR !== 1'b1) begin errors++; $display("FAIL cfg_err_after_flush got %b exp 1", CFG_ERR); end
        step();
        checks++; if (CFG_ERR !== 1'b1) begin errors++; $display("FAIL cfg_err_sticky got %b exp 1", CFG_ERR); end
        do_reset();
        checks++; if (CFG_ERR !== 1'b0) begin errors++; $display("FAIL cfg_err_after_reset got %b exp 0", CFG_ERR); end
        step();
        checks++; if (CFG_ERR !== 1'b0) begin errors++; $display("FAIL cfg_err_legal_sel got %b exp 0", CFG_ERR); end
    endtask

    task automatic test_reselect();
        DLY_SEL = 7'd6;
        do_reset();
        IN_VALID = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            IN_DATA = 32'h0005_0000 + 32'(e - 1);
            step();
        end
        checks++; if (OUT_DATA !== 32'h0005_0004) begin errors++; $display("FAIL resel_d6 got %h exp 00050004", OUT_DATA); end
        DLY_SEL = 7'd2;
        #1;
        checks++; if (OUT_DATA !== 32'h0005_0008) begin errors++; $display("FAIL resel_d2_data got %h exp 00050008", OUT_DATA); end
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL resel_d2_valid got %b exp 1", OUT_VALID); end
        checks++; if (PRIMED !== 1'b1) begin errors++; $display("FAIL resel_d2_primed got %b exp 1", PRIMED); end
        IN_DATA = 32'h0005_000A;
        step();
        checks++; if (OUT_DATA !== 32'h0005_0009) begin errors++; $display("FAIL resel_d2_next got %h exp 00050009", OUT_DATA); end
        // Widening again re-exposes s[5], captured on edge 6.
        DLY_SEL = 7'd6;
        #1;
        checks++; if (OUT_DATA !== 32'h0005_0005) begin errors++; $display("FAIL resel_back_d6 got %h exp 00050005", OUT_DATA); end
        checks++; if (CFG_ERR !== 1'b0) begin errors++; $display("FAIL resel_cfg_err got %b exp 0", CFG_ERR); end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_stall();
        test_flush();
        test_range();
        test_reselect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
